// File: rtl/tmds_encoder_if.sv
// Pixel-side bundle for one TMDS channel: data enable, pixel component,
// control bits in, 10-bit symbol out.
interface tmds_encoder_if;
  logic       de;
  logic [7:0] din;
  logic [1:0] c;
  logic [9:0] dout;

  modport master (output de, output din, output c, input dout);
  modport slave  (input de, input din, input c, output dout);
endinterface

// File: rtl/tmds_encoder.sv
// Single-channel DVI TMDS 8b/10b encoder.
// S1 applies transition minimisation to the pixel and registers q_m;
// S2 chooses the DC-balancing inversion from the running disparity and
// registers the 10-bit symbol. Blanking emits a control token and clears
// the disparity so the next active line starts from a neutral point.
module tmds_encoder #(
  parameter logic [1:0] CTRL_RESET = 2'b00
) (
  input logic        clk_dot4x,
  input logic        rst,
  tmds_encoder_if.slave bus
);

  function automatic logic [9:0] ctrl_token(input logic [1:0] sel);
    case (sel)
      2'b00:   ctrl_token = 10'b1101010100;
      2'b01:   ctrl_token = 10'b0010101011;
      2'b10:   ctrl_token = 10'b0101010100;
      default: ctrl_token = 10'b1010101011;
    endcase
  endfunction

  logic       s1_de;
  logic [1:0] s1_c;
  logic [8:0] s1_qm;

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] qm_c;

  logic signed [4:0] cnt;
  logic [3:0]        n1q;
  logic signed [5:0] diff;
  logic signed [5:0] cnt_ext;
  logic signed [5:0] cnt_n;
  logic [9:0]        dout_n;
  logic [9:0]        dout_q;

  // S1 combinational: popcount of the pixel and the XOR/XNOR chain
  always_comb begin
    logic acc;
    n1d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1d = n1d + 4'(bus.din[i]);
    end
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !bus.din[0]);
    acc      = bus.din[0];
    qm_c     = '0;
    qm_c[0]  = acc;
    for (int i = 1; i < 8; i++) begin
      acc     = use_xnor ? ~(acc ^ bus.din[i]) : (acc ^ bus.din[i]);
      qm_c[i] = acc;
    end
    qm_c[8] = ~use_xnor;
  end

  // S1 register: capture enable, control bits and the minimised word
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      s1_de <= 1'b0;
      s1_c  <= CTRL_RESET;
      s1_qm <= '0;
    end else begin
      s1_de <= bus.de;
      s1_c  <= bus.c;
      s1_qm <= qm_c;
    end
  end

  // S2 combinational: disparity-driven inversion choice and next count
  always_comb begin
    n1q = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1q = n1q + 4'(s1_qm[i]);
    end
    // N1q - N0q = 2*N1q - 8
    diff    = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    cnt_ext = $signed({cnt[4], cnt});
    dout_n  = ctrl_token(s1_c);
    cnt_n   = 6'sd0;
    if (s1_de) begin
      if ((cnt == 5'sd0) || (n1q == 4'd4)) begin
        dout_n = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
        cnt_n  = s1_qm[8] ? (cnt_ext + diff) : (cnt_ext - diff);
      end else if (((cnt > 5'sd0) && (n1q > 4'd4)) ||
                   ((cnt < 5'sd0) && (n1q < 4'd4))) begin
        dout_n = {1'b1, s1_qm[8], ~s1_qm[7:0]};
        cnt_n  = cnt_ext + (s1_qm[8] ? 6'sd2 : 6'sd0) - diff;
      end else begin
        dout_n = {1'b0, s1_qm[8], s1_qm[7:0]};
        cnt_n  = cnt_ext + diff - (s1_qm[8] ? 6'sd0 : 6'sd2);
      end
    end
  end

  // S2 register: output symbol and running disparity
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      cnt    <= 5'sd0;
      dout_q <= ctrl_token(CTRL_RESET);
    end else begin
      // |cnt| stays within 10, so the low five bits hold the full value
      cnt    <= cnt_n[4:0];
      dout_q <= dout_n;
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: doc/tmds_encoder.md
# tmds_encoder

Per-channel DVI 1.0 TMDS 8b/10b encoder. It sits downstream of the VIC-II RGB path, between the 6-to-8-bit colour scaling and the 10:1 serializer inside the DVI transmitter. Three instances are used, one each for red, green and blue. Each instance turns an 8-bit pixel value plus sync/control bits into a DC-balanced 10-bit symbol on every pixel clock, tracking running disparity across active video.

## Interface
Parameters:
- CTRL_RESET, 2'b00: control code whose token is emitted during and immediately after reset.

Ports:
- clk_dot4x  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- de  in  1  data enable. 1 = active video (encode `din`); 0 = blanking (emit control token).
- din  in  8  pixel component, 8-bit.
- c  in  2  control bits {c1,c0}. The blue channel carries {vsync,hsync}; the others carry 2'b00.
- dout  out  10  TMDS symbol, registered. `dout[0]` is transmitted first.

## Operation
- Two-stage pipeline, S1 then S2. S2 drives `dout`.
- S1 (registered):
  - Capture `de`, `c` and `din`.
  - Compute N1d = popcount(din), 4-bit.
  - Use XNOR when N1d>4, or when N1d==4 and din[0]==0; otherwise use XOR.
  - q_m[0] = din[0].
  - q_m[i] = q_m[i-1] op din[i], for i=1..7.
  - q_m[8] = 0 for XNOR, 1 for XOR.
- S2 (registered), driven by S1 outputs:
  - N1q = popcount(q_m[7:0]); N0q = 8-N1q.
  - cnt is a signed 5-bit disparity register; reset value 0.
  - Case A, cnt==0 or N1q==N0q:
    - dout = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1q-N0q) : (N0q-N1q).
  - Case B, (cnt>0 and N1q>N0q) or (cnt<0 and N0q>N1q):
    - dout = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (N0q-N1q).
  - Case C, otherwise:
    - dout = {0, q_m[8], q_m[7:0]}.
    - cnt += (N1q-N0q) - 2*(~q_m[8]).
  - When S1 de==0, the control token is selected by c:
    - 00 → 10'b1101010100
    - 01 → 10'b0010101011
    - 10 → 10'b0101010100
    - 11 → 10'b1010101011
    - cnt is forced to 0.
- Arithmetic:
  - All disparity math is signed, at least 5 bits wide.
  - |cnt| ≤ 10 is guaranteed by the algorithm; overflow handling is not required but must not occur.
- No handshake; one symbol per clock, unconditionally.

## Timing
- Latency is 2 clocks: inputs sampled at edge N appear on `dout` after edge N+1.
- Reset, while rst=1 at an edge:
  - S1 de is set to 0 and S1 c to CTRL_RESET.
  - S2 cnt is set to 0 and `dout` to the CTRL_RESET token (1101010100 for the default).
- Reset mid-active-video discards both pipeline stages. The first symbol after release is the CTRL_RESET token. Encoded data resumes at the 2nd edge after the first sampled de=1.
- Transitions:
  - de 1→0: cnt clears on the same edge that outputs the first control token.
  - de 0→1: the first data symbol uses cnt=0.
- Simultaneous de=0 and any din value: din is ignored and the token depends on c only.

## Test plan
- Reset:
  - Hold rst=1 for 3 clocks with de=1, din=0xAA.
  - Expect dout=1101010100 during reset and on the first clock after release.
  - Expect encoded data only from the 2nd post-release clock onward.
- Control tokens:
  - With de=0, step c through 00, 01, 10, 11.
  - Expect dout 1101010100, 0010101011, 0101010100, 1010101011, each 2 clocks after its input.
- Zero stream:
  - de=1, din=0x00 repeated, starting from cnt=0.
  - Expect dout 0100000000, 1111111111, 0100000000, ….
  - Expect cnt sequence -8, 2, -6, ….
- All-ones:
  - Apply din=0xFF after a blanking period.
  - Expect dout=1000000000 and cnt=-8.
- Disparity bound:
  - Run 10,000 random din values with de=1.
  - Expect |cnt| ≤ 10 always.
  - Decode each symbol with a reference TMDS decoder; decoded values must equal din with 2-cycle latency.
- Blanking interrupt:
  - Set de=0 for one clock mid-stream with c=01.
  - Expect token 0010101011 and cnt reset to 0.
  - The next data symbol must match the cnt==0 encoding.
